// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//   In-order FIFO of speculative stores sitting between the mem stage and data
//   memory. The mem stage allocates an entry per store and gets its index back
//   (for the ROB). The ROB commits entries strictly in order. Committed entries
//   drain oldest-first to data memory over a valid/ready port. Uncommitted
//   entries can be dropped on a flush. Younger loads probe the buffer and
//   either forward the youngest fully-covering store or stall on a partial
//   overlap.
//
// Ports
//   clk_i, rstn_i          clock (rising edge), synchronous active-low reset
//   alloc_*                store allocation from the mem stage
//   alloc_idx_o            index the current alloc will occupy (tail)
//   full_o / empty_o       occupancy, derived from registered pointers only
//   commit_i/commit_idx_i  in-order commit from the ROB
//   discard_i              drop every uncommitted entry
//   mem_req_*              drain port to data memory (valid/ready)
//   ld_*                   load probe and forwarding result
// -----------------------------------------------------------------------------

// Protocol checker: commit ordering, hit/stall exclusivity, occupancy bound.
module store_buffer_chk #(
    parameter int NUM_ENTRIES = 4,
    parameter int IDX_W       = 2
) (
    input logic             clk_i,
    input logic             rstn_i,
    input logic             commit_i,
    input logic             commit_ok_i,
    input logic             ld_hit_i,
    input logic             ld_stall_i,
    input logic [IDX_W:0]   used_i
);

    // Sample the protocol rules once per clock while out of reset.
    always @(posedge clk_i) begin
        if (rstn_i) begin
            assert (!commit_i || commit_ok_i)
                else $error("store_buffer: commit index out of order or nothing to commit");
            assert (!(ld_hit_i && ld_stall_i))
                else $error("store_buffer: load hit and stall asserted together");
            assert (used_i <= (IDX_W+1)'(NUM_ENTRIES))
                else $error("store_buffer: occupancy exceeds depth");
        end
    end

endmodule

module store_buffer #(
    parameter int  NUM_ENTRIES = 4,
    localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    // allocation
    input  logic             alloc_valid_i,
    input  logic [31:0]      alloc_addr_i,
    input  logic [31:0]      alloc_data_i,
    input  logic [3:0]       alloc_be_i,
    output logic [IDX_W-1:0] alloc_idx_o,
    output logic             full_o,
    output logic             empty_o,
    // commit / flush
    input  logic             commit_i,
    input  logic [IDX_W-1:0] commit_idx_i,
    input  logic             discard_i,
    // drain port
    output logic             mem_req_valid_o,
    output logic [31:0]      mem_req_addr_o,
    output logic [31:0]      mem_req_data_o,
    output logic [3:0]       mem_req_be_o,
    input  logic             mem_req_ready_i,
    // load probe
    input  logic             ld_valid_i,
    input  logic [31:0]      ld_addr_i,
    input  logic [3:0]       ld_be_i,
    output logic             ld_hit_o,
    output logic [31:0]      ld_data_o,
    output logic             ld_stall_o
);

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [IDX_W:0]          head_r, cmt_r, tail_r;
    logic [IDX_W:0]          head_nxt_s, cmt_nxt_s, tail_nxt_s;
    logic [IDX_W:0]          used_s;
    logic [IDX_W-1:0]        head_idx_s, cmt_idx_s, tail_idx_s;

    logic [NUM_ENTRIES-1:0]  valid_r, cmtd_r;
    logic [NUM_ENTRIES-1:0]  valid_nxt_s, cmtd_nxt_s;
    logic [29:0]             addr_r [NUM_ENTRIES];
    logic [31:0]             data_r [NUM_ENTRIES];
    logic [3:0]              be_r   [NUM_ENTRIES];

    logic                    full_s, empty_s, req_valid_s;
    logic                    alloc_fire_s, commit_ok_s, commit_fire_s, drain_fire_s;

    logic                    fwd_hit_s, fwd_stall_s;
    logic [31:0]             fwd_data_s;
    logic [IDX_W-1:0]        slot_s;

    // Byte-offset bits of addresses play no part in word matching.
    logic                    unused_s;
    assign unused_s = ^{alloc_addr_i[1:0], ld_addr_i[1:0]};

    assign head_idx_s = head_r[IDX_W-1:0];
    assign cmt_idx_s  = cmt_r[IDX_W-1:0];
    assign tail_idx_s = tail_r[IDX_W-1:0];
    assign used_s     = tail_r - head_r;

    assign full_s      = (used_s == (IDX_W+1)'(NUM_ENTRIES));
    assign empty_s     = (tail_r == head_r);
    assign req_valid_s = (head_r != cmt_r);

    assign alloc_fire_s  = alloc_valid_i && !full_s && !discard_i;
    assign commit_ok_s   = (commit_idx_i == cmt_idx_s) && (cmt_r != tail_r);
    // An illegal commit is flagged by the checker and otherwise ignored so the
    // ordering invariant head <= cmt <= tail can never be broken.
    assign commit_fire_s = commit_i && commit_ok_s;
    assign drain_fire_s  = req_valid_s && mem_req_ready_i;

    // Next pointer values; a discard pulls tail back onto the post-commit cmt.
    always_comb begin
        head_nxt_s = drain_fire_s  ? head_r + (IDX_W+1)'(1) : head_r;
        cmt_nxt_s  = commit_fire_s ? cmt_r  + (IDX_W+1)'(1) : cmt_r;
        if (discard_i) begin
            tail_nxt_s = cmt_nxt_s;
        end else if (alloc_fire_s) begin
            tail_nxt_s = tail_r + (IDX_W+1)'(1);
        end else begin
            tail_nxt_s = tail_r;
        end
    end

    // Per-entry valid/committed update. Drain, alloc and commit can never target
    // the same slot in one cycle (that would need a full or empty buffer, where
    // the colliding operation is already blocked), so the chain order is safe.
    always_comb begin
        valid_nxt_s = valid_r;
        cmtd_nxt_s  = cmtd_r;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (drain_fire_s && (head_idx_s == IDX_W'(i))) begin
                valid_nxt_s[i] = 1'b0;
                cmtd_nxt_s[i]  = 1'b0;
            end else if (alloc_fire_s && (tail_idx_s == IDX_W'(i))) begin
                valid_nxt_s[i] = 1'b1;
                cmtd_nxt_s[i]  = 1'b0;
            end else if (commit_fire_s && (cmt_idx_s == IDX_W'(i))) begin
                // committing wins over a same-cycle discard
                cmtd_nxt_s[i]  = 1'b1;
            end else if (discard_i && !cmtd_r[i]) begin
                valid_nxt_s[i] = 1'b0;
            end else begin
                valid_nxt_s[i] = valid_r[i];
                cmtd_nxt_s[i]  = cmtd_r[i];
            end
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            head_r  <= {(IDX_W+1){1'b0}};
            cmt_r   <= {(IDX_W+1){1'b0}};
            tail_r  <= {(IDX_W+1){1'b0}};
            valid_r <= {NUM_ENTRIES{1'b0}};
            cmtd_r  <= {NUM_ENTRIES{1'b0}};
        end else begin
            head_r  <= head_nxt_s;
            cmt_r   <= cmt_nxt_s;
            tail_r  <= tail_nxt_s;
            valid_r <= valid_nxt_s;
            cmtd_r  <= cmtd_nxt_s;
        end
    end

    // Entry payload; qualified by valid_r, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (alloc_fire_s) begin
            addr_r[tail_idx_s] <= alloc_addr_i[31:2];
            data_r[tail_idx_s] <= alloc_data_i;
            be_r[tail_idx_s]   <= alloc_be_i;
        end
    end

    // Forwarding search. Walking oldest to youngest and letting every
    // overlapping match overwrite the result leaves the youngest overlapping
    // entry in charge; entries touching none of the load lanes are skipped.
    always_comb begin
        fwd_hit_s   = 1'b0;
        fwd_stall_s = 1'b0;
        fwd_data_s  = 32'h0000_0000;
        slot_s      = {IDX_W{1'b0}};
        if (ld_valid_i) begin
            for (int k = 0; k < NUM_ENTRIES; k++) begin
                slot_s = head_idx_s + IDX_W'(k);
                if (((IDX_W+1)'(k) < used_s) && valid_r[slot_s] &&
                    (addr_r[slot_s] == ld_addr_i[31:2])) begin
                    if ((be_r[slot_s] & ld_be_i) == ld_be_i) begin
                        fwd_hit_s   = 1'b1;
                        fwd_stall_s = 1'b0;
                        fwd_data_s  = data_r[slot_s];
                    end else if ((be_r[slot_s] & ld_be_i) != 4'h0) begin
                        fwd_hit_s   = 1'b0;
                        fwd_stall_s = 1'b1;
                        fwd_data_s  = 32'h0000_0000;
                    end else begin
                        // disjoint lanes: the older result stands
                    end
                end else begin
                    // not in the live window or different word
                end
            end
        end else begin
            // no probe: defaults hold
        end
    end

    assign alloc_idx_o     = tail_idx_s;
    assign full_o          = full_s;
    assign empty_o         = empty_s;

    assign mem_req_valid_o = req_valid_s;
    assign mem_req_addr_o  = req_valid_s ? {addr_r[head_idx_s], 2'b00} : 32'h0000_0000;
    assign mem_req_data_o  = req_valid_s ? data_r[head_idx_s] : 32'h0000_0000;
    assign mem_req_be_o    = req_valid_s ? be_r[head_idx_s] : 4'h0;

    assign ld_hit_o        = fwd_hit_s;
    assign ld_stall_o      = fwd_stall_s;
    assign ld_data_o       = fwd_data_s;

    store_buffer_chk #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .IDX_W       (IDX_W)
    ) u_chk (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .commit_i    (commit_i),
        .commit_ok_i (commit_ok_s),
        .ld_hit_i    (fwd_hit_s),
        .ld_stall_i  (fwd_stall_s),
        .used_i      (used_s)
    );

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
//   Directed, self-checking bench for store_buffer (NUM_ENTRIES = 4). Inputs
//   change 1 time unit after a rising edge; outputs are sampled 1 unit later.
// -----------------------------------------------------------------------------
module tb_store_buffer;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        alloc_valid_i;
    logic [31:0] alloc_addr_i;
    logic [31:0] alloc_data_i;
    logic [3:0]  alloc_be_i;
    logic [1:0]  alloc_idx_o;
    logic        full_o, empty_o;
    logic        commit_i;
    logic [1:0]  commit_idx_i;
    logic        discard_i;
    logic        mem_req_valid_o;
    logic [31:0] mem_req_addr_o, mem_req_data_o;
    logic [3:0]  mem_req_be_o;
    logic        mem_req_ready_i;
    logic        ld_valid_i;
    logic [31:0] ld_addr_i;
    logic [3:0]  ld_be_i;
    logic        ld_hit_o, ld_stall_o;
    logic [31:0] ld_data_o;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    always #5 clk_i = ~clk_i;

    store_buffer #(.NUM_ENTRIES(4)) dut (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .alloc_valid_i   (alloc_valid_i),
        .alloc_addr_i    (alloc_addr_i),
        .alloc_data_i    (alloc_data_i),
        .alloc_be_i      (alloc_be_i),
        .alloc_idx_o     (alloc_idx_o),
        .full_o          (full_o),
        .empty_o         (empty_o),
        .commit_i        (commit_i),
        .commit_idx_i    (commit_idx_i),
        .discard_i       (discard_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_req_data_o  (mem_req_data_o),
        .mem_req_be_o    (mem_req_be_o),
        .mem_req_ready_i (mem_req_ready_i),
        .ld_valid_i      (ld_valid_i),
        .ld_addr_i       (ld_addr_i),
        .ld_be_i         (ld_be_i),
        .ld_hit_o        (ld_hit_o),
        .ld_data_o       (ld_data_o),
        .ld_stall_o      (ld_stall_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk_i);
        #1;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        alloc_valid_i = 1'b1;
        alloc_addr_i  = a;
        alloc_data_i  = d;
        alloc_be_i    = be;
    endtask

    initial begin
        rstn_i = 1'b0; alloc_valid_i = 1'b0; alloc_addr_i = 32'h0; alloc_data_i = 32'h0;
        alloc_be_i = 4'h0; commit_i = 1'b0; commit_idx_i = 2'd0; discard_i = 1'b0;
        mem_req_ready_i = 1'b0; ld_valid_i = 1'b0; ld_addr_i = 32'h0; ld_be_i = 4'h0;
        clk1();
        clk1();
        rstn_i = 1'b1;
        #1;
        chk("rst_full",   32'(full_o), 32'd0);
        chk("rst_empty",  32'(empty_o), 32'd1);
        chk("rst_reqv",   32'(mem_req_valid_o), 32'd0);
        chk("rst_hit",    32'(ld_hit_o), 32'd0);
        chk("rst_stall",  32'(ld_stall_o), 32'd0);
        chk("rst_idx",    32'(alloc_idx_o), 32'd0);

        // fill all four entries
        for (int i = 0; i < 4; i++) begin
            put(32'h100 + 32'(i * 4), 32'hA0 + 32'(i), 4'hF);
            #1;
            chk("fill_idx",  32'(alloc_idx_o), 32'(i));
            chk("fill_full", 32'(full_o), 32'd0);
            clk1();
        end
        alloc_valid_i = 1'b0;
        #1;
        chk("full_set",   32'(full_o), 32'd1);
        chk("full_nempty",32'(empty_o), 32'd0);
        put(32'h110, 32'hA4, 4'hF);
        #1;
        chk("full_idx",   32'(alloc_idx_o), 32'd0);
        clk1();
        alloc_valid_i = 1'b0;
        #1;
        chk("tail_held",  32'(alloc_idx_o), 32'd0);
        chk("still_full", 32'(full_o), 32'd1);

        // commit entry 0, hold memory off for three cycles
        commit_i = 1'b1; commit_idx_i = 2'd0;
        #1;
        chk("cmt_latency", 32'(mem_req_valid_o), 32'd0);
        clk1();
        commit_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_valid", 32'(mem_req_valid_o), 32'd1);
            chk("bp_addr",  mem_req_addr_o, 32'h100);
            chk("bp_data",  mem_req_data_o, 32'hA0);
            clk1();
        end
        mem_req_ready_i = 1'b1;
        #1;
        chk("bp_be", 32'(mem_req_be_o), 32'hF);
        clk1();
        mem_req_ready_i = 1'b0;
        #1;
        chk("drained_valid", 32'(mem_req_valid_o), 32'd0);
        chk("drained_full",  32'(full_o), 32'd0);
        chk("drained_empty", 32'(empty_o), 32'd0);
        ld_valid_i = 1'b1; ld_addr_i = 32'h100; ld_be_i = 4'hF;
        #1;
        chk("drained_nofwd", 32'(ld_hit_o), 32'd0);
        ld_valid_i = 1'b0;

        // flush the three uncommitted entries: head=cmt=tail=1
        discard_i = 1'b1;
        clk1();
        discard_i = 1'b0;
        #1;
        chk("disc_empty", 32'(empty_o), 32'd1);
        chk("disc_idx",   32'(alloc_idx_o), 32'd1);

        // allocate three, then commit+discard+alloc in one cycle
        for (int i = 0; i < 3; i++) begin
            put(32'h500 + 32'(i * 4), 32'h5500 + 32'(i), 4'hF);
            #1;
            chk("a3_idx", 32'(alloc_idx_o), 32'(1 + i));
            clk1();
        end
        put(32'h50C, 32'h5503, 4'hF);
        commit_i = 1'b1; commit_idx_i = 2'd1; discard_i = 1'b1;
        clk1();
        alloc_valid_i = 1'b0; commit_i = 1'b0; discard_i = 1'b0;
        #1;
        chk("cd_idx",   32'(alloc_idx_o), 32'd2);
        chk("cd_empty", 32'(empty_o), 32'd0);
        chk("cd_reqv",  32'(mem_req_valid_o), 32'd1);
        chk("cd_addr",  mem_req_addr_o, 32'h500);
        chk("cd_data",  mem_req_data_o, 32'h5500);
        ld_valid_i = 1'b1; ld_addr_i = 32'h504; ld_be_i = 4'hF;
        #1;
        chk("cd_dropped_nofwd", 32'(ld_hit_o), 32'd0);
        ld_addr_i = 32'h500;
        #1;
        chk("cd_kept_hit",  32'(ld_hit_o), 32'd1);
        chk("cd_kept_data", ld_data_o, 32'h5500);
        ld_valid_i = 1'b0;
        mem_req_ready_i = 1'b1;
        clk1();
        mem_req_ready_i = 1'b0;
        #1;
        chk("cd_drain_empty", 32'(empty_o), 32'd1);
        chk("cd_drain_reqv",  32'(mem_req_valid_o), 32'd0);

        // forwarding: full hit and partial overlap (entries at idx 2, 3)
        put(32'h200, 32'hDEADBEEF, 4'hF);
        clk1();
        put(32'h300, 32'h000000AB, 4'h1);
        clk1();
        alloc_valid_i = 1'b0;
        ld_valid_i = 1'b1; ld_addr_i = 32'h202; ld_be_i = 4'hC;
        #1;
        chk("fwd_hit",     32'(ld_hit_o), 32'd1);
        chk("fwd_data",    ld_data_o, 32'hDEADBEEF);
        chk("fwd_nostall", 32'(ld_stall_o), 32'd0);
        ld_addr_i = 32'h300; ld_be_i = 4'h3;
        #1;
        chk("part_stall", 32'(ld_stall_o), 32'd1);
        chk("part_nohit", 32'(ld_hit_o), 32'd0);
        chk("part_data",  ld_data_o, 32'h0);
        ld_be_i = 4'h1;
        #1;
        chk("lane_hit",  32'(ld_hit_o), 32'd1);
        chk("lane_data", ld_data_o, 32'h000000AB);
        ld_addr_i = 32'h204; ld_be_i = 4'hF;
        #1;
        chk("miss_hit",   32'(ld_hit_o), 32'd0);
        chk("miss_stall", 32'(ld_stall_o), 32'd0);
        ld_valid_i = 1'b0; ld_addr_i = 32'h200;
        #1;
        chk("idle_hit",  32'(ld_hit_o), 32'd0);
        chk("idle_data", ld_data_o, 32'h0);

        // two stores to one word across the wrap: youngest wins
        put(32'h400, 32'h11111111, 4'hF);
        #1;
        chk("wrap_idx0", 32'(alloc_idx_o), 32'd0);
        clk1();
        put(32'h400, 32'h22222222, 4'hF);
        #1;
        chk("wrap_idx1", 32'(alloc_idx_o), 32'd1);
        clk1();
        alloc_valid_i = 1'b0;
        ld_valid_i = 1'b1; ld_addr_i = 32'h400; ld_be_i = 4'hF;
        #1;
        chk("young_hit",  32'(ld_hit_o), 32'd1);
        chk("young_data", ld_data_o, 32'h22222222);
        chk("young_full", 32'(full_o), 32'd1);
        ld_valid_i = 1'b0;
        discard_i = 1'b1;
        clk1();
        discard_i = 1'b0;
        #1;
        chk("disc2_empty", 32'(empty_o), 32'd1);
        chk("disc2_idx",   32'(alloc_idx_o), 32'd2);

        // ten alloc/commit/drain rounds; pointers start at 2 and wrap
        for (int r = 0; r < 10; r++) begin
            put(32'h800 + 32'(r * 4), 32'hC000 + 32'(r), 4'hF);
            #1;
            chk("rnd_idx", 32'(alloc_idx_o), 32'((2 + r) % 4));
            clk1();
            alloc_valid_i = 1'b0;
            commit_i = 1'b1; commit_idx_i = 2'((2 + r) % 4); mem_req_ready_i = 1'b1;
            clk1();
            commit_i = 1'b0;
            #1;
            chk("rnd_reqv", 32'(mem_req_valid_o), 32'd1);
            chk("rnd_addr", mem_req_addr_o, 32'h800 + 32'(r * 4));
            chk("rnd_data", mem_req_data_o, 32'hC000 + 32'(r));
            clk1();
            mem_req_ready_i = 1'b0;
            #1;
            chk("rnd_empty", 32'(empty_o), 32'd1);
        end

        // reset in the middle of a stalled drain (tail now at idx 0)
        put(32'h900, 32'h9999, 4'hF);
        clk1();
        alloc_valid_i = 1'b0;
        commit_i = 1'b1; commit_idx_i = 2'd0;
        clk1();
        commit_i = 1'b0;
        #1;
        chk("mid_reqv", 32'(mem_req_valid_o), 32'd1);
        rstn_i = 1'b0;
        clk1();
        rstn_i = 1'b1;
        #1;
        chk("mr_empty", 32'(empty_o), 32'd1);
        chk("mr_reqv",  32'(mem_req_valid_o), 32'd0);
        chk("mr_full",  32'(full_o), 32'd0);
        chk("mr_idx",   32'(alloc_idx_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
